// File: rtl/fp_conv_sched.sv
// Round-robin scheduler sharing one external bi_to_float converter between two
// requesters; results come back tagged with the requester ID.
module fp_conv_sched #(
    parameter int CONV_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [11:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_data,
    output logic        req1_ready,
    output logic [11:0] conv_bi,
    input  logic [7:0]  conv_ft,
    output logic        out_valid,
    output logic [7:0]  out_ft,
    output logic        out_id,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] conv_count
);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(CONV_LAT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  wait_q, wait_d;
    logic [11:0] conv_bi_q, conv_bi_d;
    logic [7:0]  out_ft_q, out_ft_d;
    logic        out_id_q, out_id_d;
    logic [15:0] conv_count_q, conv_count_d;
    logic        grant0, grant1;

    // Under contention the requester that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wait_q       <= 4'd0;
            conv_bi_q    <= 12'h000;
            out_ft_q     <= 8'h00;
            out_id_q     <= 1'b0;
            conv_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
            conv_bi_q    <= conv_bi_d;
            out_ft_q     <= out_ft_d;
            out_id_q     <= out_id_d;
            conv_count_q <= conv_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        conv_bi_d    = conv_bi_q;
        out_ft_d     = out_ft_q;
        out_id_d     = out_id_q;
        conv_count_d = conv_count_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = CONV;
                    conv_bi_d    = grant0 ? req0_data : req1_data;
                    out_id_d     = grant1;
                    last_grant_d = grant1;
                    wait_d       = LAT_M1;
                end
            end
            CONV: begin
                if (wait_q == 4'd0) begin
                    out_ft_d = conv_ft;
                    state_d  = OUT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    conv_count_d = conv_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && grant0;
        req1_ready = (state_q == IDLE) && grant1;
        out_valid  = (state_q == OUT);
        busy       = (state_q != IDLE);
    end

    assign conv_bi    = conv_bi_q;
    assign out_ft     = out_ft_q;
    assign out_id     = out_id_q;
    assign conv_count = conv_count_q;

endmodule

// File: tb/tb_fp_conv_sched.sv
// Directed bench for fp_conv_sched: one instance at CONV_LAT=1, one at CONV_LAT=4,
// each fed by a behavioural bi_to_float converter.
module tb_fp_conv_sched;

    logic        clk = 1'b0;
    logic        rst_n, rst4_n;
    logic        req0_valid, req1_valid, out_ready;
    logic [11:0] req0_data, req1_data;

    logic        req0_ready, req1_ready, out_valid, out_id, busy;
    logic [11:0] conv_bi;
    logic [7:0]  conv_ft, out_ft;
    logic [15:0] conv_count;

    logic        req0_ready4, req1_ready4, out_valid4, out_id4, busy4;
    logic [11:0] conv_bi4;
    logic [7:0]  conv_ft4, out_ft4;
    logic [15:0] conv_count4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Behavioural converter: sign-magnitude, magnitude shifted right until it fits 4 bits.
    function automatic logic [7:0] to_float(input logic [11:0] bi);
        logic [11:0] mag;
        logic [2:0]  e;
        mag = bi[11] ? (~bi + 12'd1) : bi;
        e = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (mag > 12'd15) begin
                mag = mag >> 1;
                e = e + 3'd1;
            end
        end
        return {bi[11], e, mag[3:0]};
    endfunction

    assign conv_ft  = to_float(conv_bi);
    assign conv_ft4 = to_float(conv_bi4);

    fp_conv_sched #(.CONV_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .conv_bi(conv_bi), .conv_ft(conv_ft),
        .out_valid(out_valid), .out_ft(out_ft), .out_id(out_id), .out_ready(out_ready),
        .busy(busy), .conv_count(conv_count)
    );

    fp_conv_sched #(.CONV_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready4),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready4),
        .conv_bi(conv_bi4), .conv_ft(conv_ft4),
        .out_valid(out_valid4), .out_ft(out_ft4), .out_id(out_id4), .out_ready(out_ready),
        .busy(busy4), .conv_count(conv_count4)
    );

    task automatic pulse_reset1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready, conv_bi, out_valid, out_ft, out_id, busy, conv_count} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got r0=%b r1=%b bi=%h ov=%b ft=%h id=%b busy=%b cnt=%h expected all zero",
                     req0_ready, req1_ready, conv_bi, out_valid, out_ft, out_id, busy, conv_count);
        end
        tests_run++;
        if ({req0_ready4, req1_ready4, conv_bi4, out_valid4, out_ft4, out_id4, busy4, conv_count4} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_values_lat4: got bi=%h ov=%b ft=%h busy=%b cnt=%h expected all zero",
                     conv_bi4, out_valid4, out_ft4, busy4, conv_count4);
        end
        $display("[TB] reset: checked reset values");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data = 12'h1A6;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b1 || conv_bi !== 12'h1A6 || req0_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_conv: got busy=%b bi=%h r0=%b ov=%b expected busy=1 bi=1a6 r0=0 ov=0",
                     busy, conv_bi, req0_ready, out_valid);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_ft !== 8'h5D || out_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_result: got ov=%b ft=%h id=%b expected ov=1 ft=5d id=0", out_valid, out_ft, out_id);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || conv_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_done: got ov=%b busy=%b cnt=%h expected ov=0 busy=0 cnt=0001", out_valid, busy, conv_count);
        end
        $display("[TB] single: 1a6 -> ft=%h id=%b cnt=%0d", out_ft, out_id, conv_count);
        @(negedge clk);
    endtask

    task automatic test_contention;
        pulse_reset1();
        out_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data = 12'hE5A;
        req1_valid = 1'b1;
        req1_data = 12'h1A6;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_first: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        tests_run++;
        if (req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_hold_conv: got r1=%b expected 0", req1_ready);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_ft !== 8'hDD || out_id !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_res0: got ov=%b ft=%h id=%b r1=%b expected ov=1 ft=dd id=0 r1=0",
                     out_valid, out_ft, out_id, req1_ready);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_second: got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_ft !== 8'h5D || out_id !== 1'b1) begin
            tests_failed++;
            $display("FAIL contention_res1: got ov=%b ft=%h id=%b expected ov=1 ft=5d id=1", out_valid, out_ft, out_id);
        end
        $display("[TB] contention: e5a/1a6 -> dd id0 then %h id%b", out_ft, out_id);
        @(negedge clk);
    endtask

    task automatic test_alternation;
        logic [11:0] d0[3];
        logic [11:0] d1[3];
        logic [7:0]  e0[3];
        logic [7:0]  e1[3];
        logic [7:0]  exp_ft;
        int k0, k1, ng, nr, last_cyc;
        bit pend0, pend1;
        d0[0] = 12'h1A6; d0[1] = 12'h005; d0[2] = 12'hFFF;
        e0[0] = 8'h5D;   e0[1] = 8'h05;   e0[2] = 8'h81;
        d1[0] = 12'hE5A; d1[1] = 12'h010; d1[2] = 12'h07F;
        e1[0] = 8'hDD;   e1[1] = 8'h18;   e1[2] = 8'h3F;
        k0 = 0; k1 = 0; ng = 0; nr = 0; last_cyc = 0; pend0 = 0; pend1 = 0;
        pulse_reset1();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = d0[0];
        req1_valid = 1'b1; req1_data = d1[0];
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (pend0) begin
                k0++; pend0 = 0;
                if (k0 < 3) req0_data = d0[k0]; else req0_valid = 1'b0;
            end
            if (pend1) begin
                k1++; pend1 = 0;
                if (k1 < 3) req1_data = d1[k1]; else req1_valid = 1'b0;
            end
            #1;
            if (req0_ready || req1_ready) begin
                tests_run++;
                if (req1_ready !== ng[0] || (req0_ready && req1_ready)) begin
                    tests_failed++;
                    $display("FAIL alt_grant_order: grant %0d got r0=%b r1=%b expected requester %0d",
                             ng, req0_ready, req1_ready, ng[0]);
                end
                if (ng > 0) begin
                    // Counted inclusively from one grant cycle through the next.
                    tests_run++;
                    if (cyc - last_cyc + 1 != 4) begin
                        tests_failed++;
                        $display("FAIL alt_turnaround: grant %0d got %0d cycles expected 4", ng, cyc - last_cyc + 1);
                    end
                end
                $display("[TB] alternation: grant %0d to requester %0d at cycle %0d", ng, req1_ready, cyc);
                last_cyc = cyc;
                ng++;
                if (req1_ready) pend1 = 1; else pend0 = 1;
            end
            if (out_valid && nr < 6) begin
                exp_ft = nr[0] ? e1[nr >> 1] : e0[nr >> 1];
                tests_run++;
                if (out_id !== nr[0] || out_ft !== exp_ft) begin
                    tests_failed++;
                    $display("FAIL alt_result: result %0d got ft=%h id=%b expected ft=%h id=%0d",
                             nr, out_ft, out_id, exp_ft, nr[0]);
                end
                nr++;
            end
            @(negedge clk);
        end
        tests_run++;
        if (ng != 6 || nr != 6) begin
            tests_failed++;
            $display("FAIL alt_counts: got grants=%0d results=%0d expected 6 and 6", ng, nr);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int n;
        pulse_reset1();
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 12'h1A6;
        req1_valid = 1'b1; req1_data = 12'hE5A;
        @(negedge clk);
        #1;
        n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_timeout: got ov=%b after %0d cycles expected 1", out_valid, n);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_ft !== 8'h5D || out_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_stall: cycle %0d got ov=%b ft=%h id=%b r0=%b r1=%b busy=%b expected 1 5d 0 0 0 1",
                         i, out_valid, out_ft, out_id, req0_ready, req1_ready, busy);
            end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || conv_count !== 16'd1 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got ov=%b cnt=%h r0=%b r1=%b expected ov=0 cnt=0001 r0=0 r1=1",
                     out_valid, conv_count, req0_ready, req1_ready);
        end
        $display("[TB] backpressure: held 10 cycles, released cnt=%0d", conv_count);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int n;
        rst_n = 1'b0;
        rst4_n = 1'b1;
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 12'h07F;
        #1;
        tests_run++;
        if (req0_ready4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat4_grant: got r0=%b expected 1", req0_ready4);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n = 1;
        while (out_valid4 !== 1'b1 && n < 12) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (n != 5 || out_valid4 !== 1'b1 || out_ft4 !== 8'h3F || out_id4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat4_result: got latency=%0d ov=%b ft=%h id=%b expected 5 1 3f 0", n, out_valid4, out_ft4, out_id4);
        end
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 12'h1A6;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (busy4 !== 1'b1 || conv_bi4 !== 12'h1A6 || conv_count4 !== 16'd1) begin
            tests_failed++;
            $display("FAIL lat4_inflight: got busy=%b bi=%h cnt=%h expected 1 1a6 0001", busy4, conv_bi4, conv_count4);
        end
        #2;
        rst4_n = 1'b0;
        #1;
        tests_run++;
        if ({req0_ready4, req1_ready4, conv_bi4, out_valid4, out_ft4, out_id4, busy4, conv_count4} !== 41'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got bi=%h ov=%b ft=%h id=%b busy=%b cnt=%h expected all zero",
                     conv_bi4, out_valid4, out_ft4, out_id4, busy4, conv_count4);
        end
        @(negedge clk);
        rst4_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (out_valid4 === 1'b1) n++;
        end
        tests_run++;
        if (n != 0) begin
            tests_failed++;
            $display("FAIL discarded_result: got out_valid high %0d cycles expected 0", n);
        end
        req0_valid = 1'b1; req0_data = 12'h005;
        req1_valid = 1'b1; req1_data = 12'h010;
        #1;
        tests_run++;
        if (req0_ready4 !== 1'b1 || req1_ready4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got r0=%b r1=%b expected r0=1 r1=0", req0_ready4, req1_ready4);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        n = 0;
        while (out_valid4 !== 1'b1 && n < 12) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (out_valid4 !== 1'b1 || out_ft4 !== 8'h05 || out_id4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_result: got ov=%b ft=%h id=%b expected 1 05 0", out_valid4, out_ft4, out_id4);
        end
        $display("[TB] async_reset: discarded 1a6, next grant to requester %b ft=%h", out_id4, out_ft4);
        @(negedge clk);
        rst4_n = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_wrap;
        logic [15:0] exp_cnt[2];
        int n;
        exp_cnt[0] = 16'hFFFF;
        exp_cnt[1] = 16'h0000;
        pulse_reset1();
        force u_dut.conv_count_q = 16'hFFFE;
        #1;
        release u_dut.conv_count_q;
        #1;
        tests_run++;
        if (conv_count !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL wrap_preload: got %h expected fffe", conv_count);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req1_valid = 1'b1; req1_data = 12'h005;
            @(negedge clk);
            req1_valid = 1'b0;
            #1;
            n = 0;
            while (out_valid !== 1'b1 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            tests_run++;
            if (out_valid !== 1'b1 || out_ft !== 8'h05 || out_id !== 1'b1) begin
                tests_failed++;
                $display("FAIL wrap_result: conv %0d got ov=%b ft=%h id=%b expected 1 05 1", k, out_valid, out_ft, out_id);
            end
            @(negedge clk);
            #1;
            tests_run++;
            if (conv_count !== exp_cnt[k]) begin
                tests_failed++;
                $display("FAIL wrap_count: conv %0d got %h expected %h", k, conv_count, exp_cnt[k]);
            end
            $display("[TB] count_wrap: conversion %0d cnt=%h", k, conv_count);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rst4_n = 1'b0;
        req0_valid = 1'b0; req0_data = 12'h000;
        req1_valid = 1'b0; req1_data = 12'h000;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_alternation();
        test_backpressure();
        test_async_reset();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
